mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter STREAK_MAX, 4, max consecutive data grants while fetch waits.
REQ-004 Parameter TIMEOUT, 255, max cycles waiting for mem_ready.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Ports i_req (input, 1) and i_addr (input, AW): fetch-side read request.
REQ-008 Ports i_ack (output, 1) and i_rdata (output, DW): fetch completion, as a one-cycle pulse plus data.
REQ-009 Ports d_req (input, 1), d_we (input, 1), d_be (input, 4), d_addr (input, AW) and d_wdata (input, DW): data-side request.
REQ-010 Ports d_ack (output, 1) and d_rdata (output, DW): data completion, as a one-cycle pulse plus data.
REQ-011 Ports i_stall and d_stall (output, 1 each): stall requests to the hazard unit.
REQ-012 Ports mem_req, mem_we, mem_be, mem_addr and mem_wdata (outputs): single shared memory port.
REQ-013 Ports mem_ready (input, 1) and mem_rdata (input, DW): memory completion.
REQ-014 Port err (output, 1): sticky timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE, I_BUSY and D_BUSY, with at most one memory transaction outstanding.
REQ-016 Arbitration SHALL grant d_req over i_req, except that once streak reaches STREAK_MAX with i_req pending, the fetch side SHALL be granted next.
REQ-017 streak SHALL increment on each data grant while i_req=1, clear on any fetch grant or whenever i_req=0, and saturate at STREAK_MAX.
REQ-018 Latency: a request sampled at edge N SHALL drive mem_req=1 with registered addr/we/be/wdata from cycle N+1.
REQ-019 All mem_* outputs SHALL stay stable until the cycle in which mem_ready=1.
REQ-020 A fetch SHALL drive mem_we=0 and mem_be=4'hF.
REQ-021 When mem_ready=1 in a BUSY state, the matching ack SHALL pulse for exactly one cycle on the next cycle, and the matching rdata SHALL be registered from mem_rdata.
REQ-022 rdata SHALL hold its value until the next ack for that side; a write SHALL also produce d_ack.
REQ-023 On completion, the FSM SHALL re-arbitrate in the same edge, with no idle bubble: the next mem_req appears in the same cycle as the previous ack.
REQ-024 i_stall SHALL equal i_req AND NOT i_ack, and d_stall SHALL equal d_req AND NOT d_ack (combinational).
REQ-025 Requesters hold req and payload stable until ack; if a request drops mid-transaction, the transaction SHALL complete and its ack SHALL still pulse.
REQ-026 i_req and d_req arriving in the same IDLE cycle SHALL resolve per REQ-016.
REQ-027 The timeout counter SHALL clear on each grant and count BUSY cycles.
REQ-028 When the count reaches TIMEOUT without mem_ready, the block SHALL set err, drop mem_req, pulse the pending ack with rdata={DW{1'b1}}, and return to IDLE.
REQ-029 mem_ready in IDLE SHALL be ignored.

Reset
REQ-030 Asserting rst SHALL force state=IDLE, streak=0, timer=0 and err=0.
REQ-031 Asserting rst SHALL force mem_req, mem_we, mem_be, mem_addr and mem_wdata to 0.
REQ-032 Asserting rst SHALL force i_ack, d_ack, i_rdata and d_rdata to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no ack; the first grant is sampled on the first edge after rst deasserts.
REQ-034 err SHALL clear only on reset.

Structure
REQ-035 The state encoding, the STREAK_MAX and TIMEOUT defaults, and the fetch-side byte-enable constant SHALL live in shared package mem_arb_pkg.
REQ-036 The timeout counter SHALL be sub-module arb_timeout_cnt (clear, enable, expired), with arbitration and FSM kept in the top level.

Verification
REQ-037 Single fetch: i_req=1, i_addr=0x40 at cycle 0, mem_ready=1 at cycle 3 -> mem_req in cycles 1-3, i_ack in cycle 4 only, i_rdata=mem_rdata.
REQ-038 Simultaneous requests: i_req and d_req (sw, d_addr=0x100) in cycle 0 -> data granted first, then fetch with its mem_req in the same cycle as d_ack, with zero-wait memory.
REQ-039 Starvation: d_req held high over 6 back-to-back loads with i_req=1 -> grant order D, D, D, D, I, D.
REQ-040 Timeout: grant, then mem_ready held 0 for TIMEOUT cycles -> err=1, ack pulses with rdata=0xFFFFFFFF, state IDLE, err stays 1.
REQ-041 Reset while in D_BUSY -> all outputs 0 asynchronously, no d_ack; after release, a new i_req is serviced normally.
REQ-042 Dropped request: d_req falls one cycle after grant -> mem_* held until mem_ready, d_ack still pulses once.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the FSM encoding, the default limits and the fixed fetch byte-enable.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arb_state_t;

   localparam int STREAK_MAX_DEFAULT = 4;
   localparam int TIMEOUT_DEFAULT    = 255;

   // Fetches always read a whole word.
   localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Counts busy cycles spent waiting on the memory; flags the last allowed one.
// expired is combinational so the owner can abort on the same edge.
module arb_timeout_cnt
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // count_reg holds the number of waiting cycles already elapsed.
   assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port, one transaction
// at a time, with data priority bounded by a fetch-starvation streak limit.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STREAK_MAX = STREAK_MAX_DEFAULT,
   parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [3:0]    d_be,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          i_stall,
   output logic          d_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata,
   output logic          err
);

   localparam int SW = (STREAK_MAX < 2) ? 1 : $clog2(STREAK_MAX + 1);

   arb_state_t    state_reg, state_next;
   logic [SW-1:0] streak_reg;
   logic          grant_i, grant_d, load, busy, complete, tmo_expired;

   assign busy     = (state_reg == I_BUSY) || (state_reg == D_BUSY);
   assign complete = busy && mem_ready;

   assign grant_i  = i_req && (!d_req || (streak_reg >= SW'(STREAK_MAX)));
   assign grant_d  = d_req && !grant_i;

   assign i_stall  = i_req && !i_ack;
   assign d_stall  = d_req && !d_ack;

   arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (load),
      .enable  (busy && !mem_ready),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Completion re-arbitrates on the same edge so the port never idles.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_i || grant_d) begin
               load       = 1'b1;
               state_next = grant_i ? I_BUSY : D_BUSY;
            end
         end
         I_BUSY, D_BUSY: begin
            if (complete && (grant_i || grant_d)) begin
               load       = 1'b1;
               state_next = grant_i ? I_BUSY : D_BUSY;
            end else if (complete || tmo_expired) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         err        <= 1'b0;
         streak_reg <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         if (complete || tmo_expired) begin
            mem_req <= 1'b0;
            if (state_reg == I_BUSY) begin
               i_ack   <= 1'b1;
               i_rdata <= complete ? mem_rdata : {DW{1'b1}};
            end else begin
               d_ack   <= 1'b1;
               d_rdata <= complete ? mem_rdata : {DW{1'b1}};
            end
            if (tmo_expired) begin
               err <= 1'b1;
            end
         end
         if (load) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_d ? d_we : 1'b0;
            mem_be    <= grant_d ? d_be : FETCH_BE;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
         end
         // Streak only grows while a fetch is actually being passed over.
         if (!i_req || (load && grant_i)) begin
            streak_reg <= '0;
         end else if (load && grant_d && (streak_reg < SW'(STREAK_MAX))) begin
            streak_reg <= streak_reg + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are checked
// on the falling edge, one cycle per step, with hand-computed expectations.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_we, mem_ready;
   logic [AW-1:0] i_addr, d_addr;
   logic [3:0]    d_be;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic          i_ack, d_ack, i_stall, d_stall, mem_req, mem_we, err;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .i_stall   (i_stall),
      .d_stall   (d_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
      mem_ready = 0; mem_rdata = '0;

      // ---- reset state ----
      @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_acks", {i_ack, d_ack}, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;

      // ---- single fetch, memory ready in the third busy cycle ----
      @(negedge clk);                                   // cycle 0
      i_req = 1; i_addr = 32'h40;
      #1 chk("f1_i_stall", i_stall, 1);
      @(negedge clk);                                   // cycle 1
      chk("f1_req_c1", mem_req, 1);
      chk("f1_addr", mem_addr, 32'h40);
      chk("f1_we", mem_we, 0);
      chk("f1_be", mem_be, 4'hF);
      @(negedge clk);                                   // cycle 2
      chk("f1_req_c2", mem_req, 1);
      @(negedge clk);                                   // cycle 3
      chk("f1_req_c3", mem_req, 1);
      chk("f1_no_ack_c3", i_ack, 0);
      mem_ready = 1; mem_rdata = 32'hCAFEBABE;
      i_req = 0;                                        // one-shot requester withdraws
      @(negedge clk);                                   // cycle 4
      chk("f1_ack_c4", i_ack, 1);
      chk("f1_rdata", i_rdata, 32'hCAFEBABE);
      chk("f1_req_c4", mem_req, 0);
      mem_ready = 0; mem_rdata = 32'h0;
      @(negedge clk);                                   // cycle 5
      chk("f1_ack_c5", i_ack, 0);
      chk("f1_rdata_hold", i_rdata, 32'hCAFEBABE);

      // ---- simultaneous store and fetch, zero-wait memory ----
      @(negedge clk);
      i_req = 1; i_addr = 32'h80;
      d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h100; d_wdata = 32'h12345678;
      mem_ready = 1; mem_rdata = 32'h0BADF00D;
      #1 chk("sim_d_stall", d_stall, 1);
      @(negedge clk);
      chk("sim_d_req", mem_req, 1);
      chk("sim_d_addr", mem_addr, 32'h100);
      chk("sim_d_we", mem_we, 1);
      chk("sim_d_be", mem_be, 4'h3);
      chk("sim_d_wdata", mem_wdata, 32'h12345678);
      d_req = 0;
      @(negedge clk);
      chk("sim_d_ack", d_ack, 1);
      chk("sim_i_req_with_dack", mem_req, 1);
      chk("sim_i_addr", mem_addr, 32'h80);
      chk("sim_i_we", mem_we, 0);
      chk("sim_i_stall", i_stall, 1);
      chk("sim_d_stall_ack", d_stall, 0);
      i_req = 0;
      @(negedge clk);
      chk("sim_i_ack", i_ack, 1);
      chk("sim_i_rdata", i_rdata, 32'h0BADF00D);
      chk("sim_d_ack_done", d_ack, 0);
      chk("sim_idle", mem_req, 0);
      mem_ready = 0;

      // ---- starvation bound: expected grant order D D D D I D ----
      @(negedge clk);
      i_req = 1; i_addr = 32'h300;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200; d_wdata = '0;
      mem_ready = 1; mem_rdata = 32'h11110000;
      for (int g = 0; g < 6; g++) begin
         @(negedge clk);
         chk($sformatf("stv_req_%0d", g), mem_req, 1);
         chk($sformatf("stv_addr_%0d", g), mem_addr, (g == 4) ? 32'h300 : 32'h200);
         if (g == 4) i_req = 0;
         if (g == 5) begin
            chk("stv_i_ack", i_ack, 1);
            d_req = 0;
         end
      end
      @(negedge clk);
      chk("stv_last_d_ack", d_ack, 1);
      chk("stv_idle", mem_req, 0);
      mem_ready = 0;

      // ---- timeout on a data load ----
      @(negedge clk);
      d_req = 1; d_we = 0; d_addr = 32'h400;
      for (int k = 1; k <= 255; k++) begin
         @(negedge clk);
         chk("tmo_req_held", mem_req, 1);
         chk("tmo_no_ack", d_ack, 0);
      end
      chk("tmo_err_pre", err, 0);
      @(negedge clk);
      chk("tmo_err", err, 1);
      chk("tmo_ack", d_ack, 1);
      chk("tmo_rdata", d_rdata, 32'hFFFFFFFF);
      chk("tmo_req_drop", mem_req, 0);
      d_req = 0;
      @(negedge clk);
      chk("tmo_ack_once", d_ack, 0);
      chk("tmo_idle", mem_req, 0);
      @(negedge clk);
      chk("tmo_err_sticky", err, 1);

      // ---- reset while a store is outstanding ----
      @(negedge clk);
      d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("rbusy_req", mem_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("rbusy_async_req", mem_req, 0);
      chk("rbusy_async_we", mem_we, 0);
      chk("rbusy_async_addr", mem_addr, 0);
      chk("rbusy_async_err", err, 0);
      d_req = 0;
      @(negedge clk);
      rst = 1'b0;
      chk("rbusy_no_ack", d_ack, 0);
      @(negedge clk);
      i_req = 1; i_addr = 32'h600;
      @(negedge clk);
      chk("rbusy_f_req", mem_req, 1);
      chk("rbusy_f_addr", mem_addr, 32'h600);
      mem_ready = 1; mem_rdata = 32'h600DF00D;
      i_req = 0;
      @(negedge clk);
      chk("rbusy_f_ack", i_ack, 1);
      chk("rbusy_f_rdata", i_rdata, 32'h600DF00D);
      chk("rbusy_d_quiet", d_ack, 0);
      mem_ready = 0;

      // ---- store request dropped after grant; payload must stay latched ----
      @(negedge clk);
      d_req = 1; d_we = 1; d_be = 4'hC; d_addr = 32'h700; d_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      chk("drop_req", mem_req, 1);
      d_req = 0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; d_we = 0;
      @(negedge clk);
      chk("drop_req_held", mem_req, 1);
      chk("drop_addr_held", mem_addr, 32'h700);
      chk("drop_wdata_held", mem_wdata, 32'hA5A5A5A5);
      chk("drop_be_held", mem_be, 4'hC);
      chk("drop_we_held", mem_we, 1);
      chk("drop_no_ack", d_ack, 0);
      mem_ready = 1;
      @(negedge clk);
      chk("drop_ack", d_ack, 1);
      chk("drop_idle", mem_req, 0);
      @(negedge clk);
      // mem_ready is still high here while idle; it must be ignored.
      chk("drop_ack_once", d_ack, 0);
      @(negedge clk);
      chk("idle_ready_no_dack", d_ack, 0);
      chk("idle_ready_no_iack", i_ack, 0);
      chk("idle_ready_no_req", mem_req, 0);
      mem_ready = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
